// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO behind a valid/ready handshake feeding
// an LSB-first serialiser that sends queued frames back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               sdata,
    input  logic                     sdata_valid,
    output logic                     sdata_ready,
    output logic                     txd,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] count
);

    localparam int BIT_PERIOD = 2 * CLK_PER_HALF_BIT;
    localparam int CW         = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam int DEPTH      = 1 << FIFO_DEPTH_LOG2;

    localparam logic [CW-1:0]              CTR_LAST   = CW'(BIT_PERIOD - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr;
    logic [FIFO_DEPTH_LOG2-1:0] rptr;
    logic [1:0]                 state;
    logic [CW-1:0]              ctr;
    logic [2:0]                 bitidx;
    logic [7:0]                 sh;
    logic                       ctr_last;
    logic                       push;
    logic                       pop;

    // Ready and busy depend only on registered state, so a same-cycle pop never raises ready.
    assign sdata_ready = (count != COUNT_FULL);
    assign busy        = (state != S_IDLE) || (count != '0);
    assign ctr_last    = (ctr == CTR_LAST);
    assign push        = sdata_valid && sdata_ready;
    assign pop         = (count != '0) &&
                         ((state == S_IDLE) || ((state == S_STOP) && ctr_last));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            state  <= S_IDLE;
            ctr    <= '0;
            bitidx <= '0;
            sh     <= '0;
            txd    <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            // The line level trails the state by one clock, so every level lasts a full bit period.
            case (state)
                S_START: txd <= 1'b0;
                S_DATA:  txd <= sh[0];
                default: txd <= 1'b1;
            endcase

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        sh    <= mem[rptr];
                        ctr   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (ctr_last) begin
                        ctr    <= '0;
                        bitidx <= '0;
                        state  <= S_DATA;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                S_DATA: begin
                    if (ctr_last) begin
                        sh  <= sh >> 1;
                        ctr <= '0;
                        if (bitidx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bitidx <= bitidx + 1'b1;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                default: begin
                    if (ctr_last) begin
                        ctr <= '0;
                        if (pop) begin
                            sh    <= mem[rptr];
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for the loopback/host-link path, the transmit counterpart of the board's UART receiver. Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `txd` at a baud period of `2*CLK_PER_HALF_BIT` clocks. Frames queued back-to-back are sent with no idle gap, so the host link runs at full line rate.

## Interface
- `CLK_PER_HALF_BIT`, default 5208. Half a bit period in clk cycles. Bit period E = 2*CLK_PER_HALF_BIT. Must be ≥1.
- `FIFO_DEPTH_LOG2`, default 4. FIFO holds 2^FIFO_DEPTH_LOG2 bytes. Must be ≥1.
- `clk`  input  1  system clock.
- `rstn`  input  1  synchronous, active-low reset.
- `sdata`  input  8  byte to transmit.
- `sdata_valid`  input  1  `sdata` is valid this cycle.
- `sdata_ready`  output  1  FIFO can accept a byte. A push happens on a rising clk edge when `sdata_valid & sdata_ready`.
- `txd`  output  1  serial line, idle high. Registered.
- `busy`  output  1  FIFO non-empty, or a frame is in progress.
- `count`  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers of width FIFO_DEPTH_LOG2. Pointers wrap naturally.
  - Occupancy is held in `count`.
  - `sdata_ready = (count != 2^FIFO_DEPTH_LOG2)`. It is computed from registered state only. A pop in the same cycle does not raise ready.
  - A push and a pop in the same cycle leave `count` unchanged, and both pointers advance.
- **State machine:** IDLE, START, DATA, STOP.
  - Datapath: bit counter `bitidx` (3 bits), baud counter `ctr` (0..E-1), 8-bit shift register `sh`.
  - IDLE: `txd`=1. If `count`≠0, pop the head into `sh`, set `ctr`=0, and go to START.
  - START: `txd`=0. When `ctr`==E-1, set `ctr`=0, `bitidx`=0, and go to DATA.
  - DATA: `txd`=`sh[0]`. When `ctr`==E-1: shift `sh` right and set `ctr`=0. If `bitidx`==7, go to STOP; otherwise increment `bitidx`.
  - STOP: `txd`=1. When `ctr`==E-1: if `count`≠0, pop into `sh`, set `ctr`=0, and go to START. Otherwise go to IDLE.
  - `ctr` increments every cycle in START/DATA/STOP unless it is wrapping to 0.
- **txd register:** the next-state value of `txd` is registered, so each level is held for exactly E cycles.
  - START lasts E cycles, each DATA bit lasts E cycles, and STOP lasts E cycles.
  - A full frame is exactly 10*E cycles.
- **busy:** `(state != IDLE) | (count != 0)`, registered-equivalent.
- **Errors:** none. Writes while `sdata_ready`=0 are ignored, and the data is dropped by the sender's protocol.

## Timing
- **Reset values** (any edge with `rstn`=0): `txd`=1, `sdata_ready`=1, `busy`=0, `count`=0, state IDLE, pointers 0.
  - Reset mid-frame takes effect on the next edge: the line returns high and FIFO contents are discarded.
- **Latency:** a byte accepted at edge t into an empty, idle block is popped at edge t+1. `txd` falls at edge t+2.
- **Back-to-back:** with data queued, the START of frame n+1 follows the last STOP cycle of frame n with zero idle cycles.
- **Full boundary:** at `count`=2^FIFO_DEPTH_LOG2, `sdata_ready`=0 even if a pop occurs in that cycle. Ready reasserts the cycle after the pop.
- **Pointer wrap:** pointers wrap from 2^FIFO_DEPTH_LOG2-1 to 0. Ordering is preserved across the wrap.
- **Stable mid-frame:** `sdata` changes after acceptance do not affect a frame in progress, because `sh` is loaded at pop.

## Test plan
- **Reset and idle:** `CLK_PER_HALF_BIT`=2 (E=4). Assert `rstn`=0 for 3 cycles with `sdata_valid`=1. Require `txd`=1, `count`=0, `busy`=0, `sdata_ready`=1.
- **Single byte:** E=4. Push 0x55 at edge t. Require the `txd` bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, starting at edge t+2. After that, `txd`=1 and `busy`=0 at edge t+42.
- **Back-to-back:** push 0xA3 then 0x0F on consecutive cycles. Require two contiguous 40-cycle frames with no extra high cycle between stop and start. Bits LSB-first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- **FIFO full:** `FIFO_DEPTH_LOG2`=2. Hold `sdata_valid`=1 with incrementing data 0x00…. Require that `sdata_ready` drops when `count`=4 and the rejected value is never sent. Ready returns one cycle after each pop. The received sequence has no gaps or duplicates across pointer wrap (≥10 bytes).
- **Reset mid-frame:** assert `rstn`=0 during DATA bit 3 of a 0x00 frame with 2 bytes queued. Require `txd`=1 and `count`=0 on the next edge. No further frames are sent after release.
- **Loopback:** connect `txd` to the UART receiver with matching `CLK_PER_HALF_BIT`=5208. Send 0x00, 0xFF, 0x5A. Require `rdata` to match each byte, with `ferr`=0.
